// File: rtl/fork_join_ctrl.sv
// Fork/join dispatcher: launches a masked set of workers, joins on all/any/none,
// and aborts unfinished workers when the per-request watchdog expires.
module fork_join_ctrl #(
    parameter int N_TASK = 4,
    parameter int TMO_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_mode,
    input  logic [N_TASK-1:0] req_mask,
    input  logic [TMO_W-1:0]  req_wdog,
    output logic [N_TASK-1:0] task_start,
    input  logic [N_TASK-1:0] task_done,
    output logic [N_TASK-1:0] task_abort,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_status,
    output logic [N_TASK-1:0] rsp_done_mask,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_ABORT  = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    localparam logic [1:0] MODE_ANY  = 2'b01;
    localparam logic [1:0] MODE_NONE = 2'b10;
    localparam logic [1:0] ST_OK     = 2'b00;
    localparam logic [1:0] ST_TMO    = 2'b01;
    localparam logic [1:0] ST_EMPTY  = 2'b10;

    state_t              state_q, state_d;
    logic [1:0]          mode_q, mode_d;
    logic [N_TASK-1:0]   mask_q, mask_d;
    logic [TMO_W-1:0]    wdog_q, wdog_d;
    logic [TMO_W-1:0]    cnt_q, cnt_d;
    logic [N_TASK-1:0]   done_q, done_d;
    logic [1:0]          status_q, status_d;

    logic [N_TASK-1:0]   done_next;
    logic                complete;

    // State register: control state resets, latched request fields do not
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            done_q   <= '0;
            status_q <= ST_OK;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            status_q <= status_d;
        end
    end

    always_ff @(posedge clk) begin
        mode_q <= mode_d;
        mask_q <= mask_d;
        wdog_q <= wdog_d;
    end

    // Next-state logic; mode 11 falls into the join-all comparison
    always_comb begin
        done_next = done_q | (task_done & mask_q);
        complete  = (mode_q == MODE_ANY) ? (done_next != '0) : (done_next == mask_q);

        state_d  = state_q;
        mode_d   = mode_q;
        mask_d   = mask_q;
        wdog_d   = wdog_q;
        cnt_d    = cnt_q;
        done_d   = done_q;
        status_d = status_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    mode_d   = req_mode;
                    mask_d   = req_mask;
                    wdog_d   = req_wdog;
                    done_d   = '0;
                    status_d = (req_mask == '0) ? ST_EMPTY : ST_OK;
                    state_d  = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                // An empty mask rides through LAUNCH (no start bits) so every
                // non-waiting request answers two cycles after acceptance.
                cnt_d  = wdog_q;
                done_d = done_next;
                if (mask_q == '0 || mode_q == MODE_NONE) begin
                    state_d = S_RESP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                done_d = done_next;
                if (complete) begin
                    status_d = ST_OK;
                    state_d  = S_RESP;
                end else if (wdog_q != '0 && cnt_q == TMO_W'(1)) begin
                    state_d = S_ABORT;
                end else if (wdog_q != '0) begin
                    cnt_d = cnt_q - TMO_W'(1);
                end
            end
            S_ABORT: begin
                status_d = ST_TMO;
                state_d  = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready     = (state_q == S_IDLE);
        busy          = (state_q != S_IDLE);
        task_start    = (state_q == S_LAUNCH) ? mask_q : '0;
        task_abort    = (state_q == S_ABORT) ? (mask_q & ~done_q) : '0;
        rsp_valid     = (state_q == S_RESP);
        rsp_status    = status_q;
        rsp_done_mask = done_q;
    end

endmodule

// File: tb/tb_fork_join_ctrl.sv
// Directed bench for fork_join_ctrl: join modes, watchdog expiry, empty mask,
// backpressure, mid-operation reset and unmasked done pulses.
module tb_fork_join_ctrl;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_mode;
    logic [3:0] req_mask;
    logic [15:0] req_wdog;
    logic [3:0] task_start;
    logic [3:0] task_done;
    logic [3:0] task_abort;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [1:0] rsp_status;
    logic [3:0] rsp_done_mask;
    logic       busy;

    int n_cmp;
    int n_err;
    int abort_cnt;

    fork_join_ctrl #(.N_TASK(4), .TMO_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_mode     (req_mode),
        .req_mask     (req_mask),
        .req_wdog     (req_wdog),
        .task_start   (task_start),
        .task_done    (task_done),
        .task_abort   (task_abort),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_status   (rsp_status),
        .rsp_done_mask(rsp_done_mask),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every cycle in which any abort bit is driven
    initial abort_cnt = 0;
    always @(negedge clk) begin
        if (task_abort != 4'b0000) abort_cnt = abort_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        assert (obs === exp) else begin
            n_err = n_err + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".task_start"}, 32'(task_start), 32'd0);
        chk({tag, ".task_abort"}, 32'(task_abort), 32'd0);
        chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, ".rsp_status"}, 32'(rsp_status), 32'd0);
        chk({tag, ".rsp_done_mask"}, 32'(rsp_done_mask), 32'd0);
    endtask

    // Present a request for one edge; returns in the LAUNCH cycle
    task automatic launch(input logic [1:0] mode, input logic [3:0] mask, input logic [15:0] wdog);
        req_valid = 1'b1;
        req_mode  = mode;
        req_mask  = mask;
        req_wdog  = wdog;
        step();
        req_valid = 1'b0;
        req_mode  = 2'b00;
        req_mask  = 4'b0000;
        req_wdog  = 16'd0;
    endtask

    task automatic accept_rsp();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_mode  = 2'b00;
        req_mask  = 4'b0000;
        req_wdog  = 16'd0;
        task_done = 4'b0000;
        rsp_ready = 1'b0;
        step();
        step();
        chk_reset_outputs("reset");
        rst = 1'b0;
        step();

        // Join-all 1011, wdog 20, dones at WAIT 2/5/7, stray lane-2 pulse at WAIT 3
        launch(2'b00, 4'b1011, 16'd20);
        chk("ja.start", 32'(task_start), 32'hB);
        chk("ja.req_ready", 32'(req_ready), 32'd0);
        chk("ja.busy", 32'(busy), 32'd1);
        step();
        for (int k = 1; k <= 7; k++) begin
            case (k)
                2: task_done = 4'b0001;
                3: task_done = 4'b0100;
                5: task_done = 4'b0010;
                7: task_done = 4'b1000;
                default: task_done = 4'b0000;
            endcase
            chk($sformatf("ja.wait%0d.rsp_valid", k), 32'(rsp_valid), 32'd0);
            step();
        end
        task_done = 4'b0000;
        chk("ja.rsp_valid", 32'(rsp_valid), 32'd1);
        chk("ja.status", 32'(rsp_status), 32'd0);
        chk("ja.done_mask", 32'(rsp_done_mask), 32'hB);
        chk("ja.abort_cnt", 32'(abort_cnt), 32'd0);
        accept_rsp();
        chk("ja.req_ready_after", 32'(req_ready), 32'd1);

        // Join-any 0110, no watchdog, stray lane 0 at WAIT 1, lane 2 at WAIT 3
        launch(2'b01, 4'b0110, 16'd0);
        chk("jany.start", 32'(task_start), 32'h6);
        step();
        for (int k = 1; k <= 3; k++) begin
            task_done = (k == 1) ? 4'b0001 : ((k == 3) ? 4'b0100 : 4'b0000);
            chk($sformatf("jany.wait%0d.rsp_valid", k), 32'(rsp_valid), 32'd0);
            step();
        end
        task_done = 4'b0000;
        chk("jany.rsp_valid", 32'(rsp_valid), 32'd1);
        chk("jany.status", 32'(rsp_status), 32'd0);
        chk("jany.done_mask", 32'(rsp_done_mask), 32'h4);
        // Backpressure: response must hold while done pulses are ignored
        for (int k = 1; k <= 4; k++) begin
            task_done = 4'b1111;
            step();
            chk($sformatf("bp%0d.rsp_valid", k), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp%0d.req_ready", k), 32'(req_ready), 32'd0);
            chk($sformatf("bp%0d.status", k), 32'(rsp_status), 32'd0);
            chk($sformatf("bp%0d.done_mask", k), 32'(rsp_done_mask), 32'h4);
        end
        task_done = 4'b0000;
        chk("jany.abort_cnt", 32'(abort_cnt), 32'd0);
        accept_rsp();
        chk("jany.req_ready_after", 32'(req_ready), 32'd1);

        // Join-all 1111, wdog 5, only lane 0: ABORT 6 cycles after LAUNCH
        launch(2'b00, 4'b1111, 16'd5);
        chk("to.start", 32'(task_start), 32'hF);
        step();
        for (int k = 1; k <= 5; k++) begin
            task_done = (k == 1) ? 4'b0001 : 4'b0000;
            chk($sformatf("to.wait%0d.abort", k), 32'(task_abort), 32'd0);
            chk($sformatf("to.wait%0d.rsp_valid", k), 32'(rsp_valid), 32'd0);
            step();
        end
        task_done = 4'b0000;
        chk("to.abort", 32'(task_abort), 32'hE);
        chk("to.abort_rsp_valid", 32'(rsp_valid), 32'd0);
        step();
        chk("to.rsp_valid", 32'(rsp_valid), 32'd1);
        chk("to.status", 32'(rsp_status), 32'd1);
        chk("to.done_mask", 32'(rsp_done_mask), 32'h1);
        chk("to.abort_off", 32'(task_abort), 32'd0);
        chk("to.abort_cnt", 32'(abort_cnt), 32'd1);
        accept_rsp();

        // Empty mask: no start pulse, status 10 two cycles after acceptance
        launch(2'b00, 4'b0000, 16'd3);
        chk("empty.start", 32'(task_start), 32'd0);
        chk("empty.rsp_valid_early", 32'(rsp_valid), 32'd0);
        step();
        chk("empty.rsp_valid", 32'(rsp_valid), 32'd1);
        chk("empty.status", 32'(rsp_status), 32'd2);
        chk("empty.done_mask", 32'(rsp_done_mask), 32'd0);
        accept_rsp();

        // Join-none 0011, lane 0 done during LAUNCH, unmasked lane 3 too
        launch(2'b10, 4'b0011, 16'd0);
        chk("jn.start", 32'(task_start), 32'h3);
        task_done = 4'b1001;
        step();
        task_done = 4'b0000;
        chk("jn.rsp_valid", 32'(rsp_valid), 32'd1);
        chk("jn.status", 32'(rsp_status), 32'd0);
        chk("jn.done_mask", 32'(rsp_done_mask), 32'h1);
        accept_rsp();
        chk("jn.req_ready_after", 32'(req_ready), 32'd1);

        // Last done on the expiry cycle: completion wins over timeout
        launch(2'b00, 4'b0011, 16'd3);
        step();
        for (int k = 1; k <= 3; k++) begin
            task_done = (k == 1) ? 4'b0001 : ((k == 3) ? 4'b0010 : 4'b0000);
            step();
        end
        task_done = 4'b0000;
        chk("exp.rsp_valid", 32'(rsp_valid), 32'd1);
        chk("exp.abort", 32'(task_abort), 32'd0);
        chk("exp.status", 32'(rsp_status), 32'd0);
        chk("exp.done_mask", 32'(rsp_done_mask), 32'h3);
        chk("exp.abort_cnt", 32'(abort_cnt), 32'd1);
        accept_rsp();

        // Reset while in WAIT with a partially done join
        launch(2'b00, 4'b1111, 16'd0);
        step();
        task_done = 4'b0010;
        step();
        task_done = 4'b0000;
        chk("rw.busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        chk_reset_outputs("rw");
        rst = 1'b0;
        step();
        chk("rw.abort_cnt", 32'(abort_cnt), 32'd1);
        chk("rw.idle_stays", 32'(rsp_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running expected done");
        $fatal(1, "timeout");
    end

endmodule
